// File: rtl/axi4_lite_traffic_gen_multi.sv
// AXI4-Lite master traffic generator: writes a pattern over an address window,
// reads it back, checks it, and repeats for a number of passes or until stopped.
module axi4_lite_traffic_gen_multi #(
  parameter int              ADDR_WIDTH = 28,
  parameter int              DATA_WIDTH = 64,
  parameter longint unsigned BASE_ADDR  = 0,
  parameter int              NUM_WORDS  = 256,
  parameter int              CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [1:0]              mode_i,
  input  logic [CNT_WIDTH-1:0]    passes_i,
  input  logic [31:0]             seed_i,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [2:0]              awprot_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic [2:0]              arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    pass_cnt_o,
  output logic [CNT_WIDTH-1:0]    wr_err_cnt_o,
  output logic [CNT_WIDTH-1:0]    rd_err_cnt_o,
  output logic                    err_valid_o,
  output logic [ADDR_WIDTH-1:0]   first_err_addr_o
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int SHIFT_W    = $clog2(DATA_WIDTH);
  localparam int REP        = DATA_WIDTH / 32;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [31:0]           LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [CNT_WIDTH-1:0]    passes_q, passes_d;
  logic [31:0]             seed_q, seed_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [CNT_WIDTH-1:0]    pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]    wr_err_q, wr_err_d;
  logic [CNT_WIDTH-1:0]    rd_err_q, rd_err_d;
  logic                    err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;

  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   addr_ext;
  logic [DATA_WIDTH-1:0]   pattern;
  logic [31:0]             lfsr_next;
  logic [31:0]             seed_eff;
  logic                    last_word;
  logic                    aw_fire;
  logic                    w_fire;
  logic                    rd_bad;
  logic                    unused_resp;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign cur_addr  = BASE + (ADDR_WIDTH'(idx_q) << BYTE_SHIFT);
  assign addr_ext  = DATA_WIDTH'(cur_addr);
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  assign seed_eff  = (seed_i == 32'h0) ? 32'h1 : seed_i;
  assign last_word = (idx_q == LAST_IDX);
  assign aw_fire   = awvalid_o & awready_i;
  assign w_fire    = wvalid_o & wready_i;
  assign rd_bad    = (rdata_i != pattern) | rresp_i[1];
  assign unused_resp = bresp_i[0] ^ rresp_i[0];

  // Pattern depends only on registered state, so it is stable while valids are up
  // and the read phase regenerates it identically from the reloaded seed.
  always_comb begin
    pattern = addr_ext;
    case (mode_q)
      2'd0: pattern = addr_ext;
      2'd1: pattern = ~addr_ext;
      2'd2: pattern = {REP{lfsr_q}};
      2'd3: pattern = DATA_WIDTH'(1) << SHIFT_W'(idx_q);
      default: pattern = addr_ext;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      passes_q    <= '0;
      seed_q      <= '0;
      lfsr_q      <= '0;
      idx_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      pass_cnt_q  <= '0;
      wr_err_q    <= '0;
      rd_err_q    <= '0;
      err_valid_q <= 1'b0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      passes_q    <= passes_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      pass_cnt_q  <= pass_cnt_d;
      wr_err_q    <= wr_err_d;
      rd_err_q    <= rd_err_d;
      err_valid_q <= err_valid_d;
      first_err_q <= first_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    passes_d    = passes_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    pass_cnt_d  = pass_cnt_q;
    wr_err_d    = wr_err_q;
    rd_err_d    = rd_err_q;
    err_valid_d = err_valid_q;
    first_err_d = first_err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          mode_d      = mode_i;
          passes_d    = passes_i;
          seed_d      = seed_eff;
          lfsr_d      = seed_eff;
          idx_d       = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          pass_cnt_d  = '0;
          wr_err_d    = '0;
          rd_err_d    = '0;
          err_valid_d = 1'b0;
          first_err_d = '0;
          state_d     = WR_REQ;
        end
      end

      WR_REQ: begin
        // AW and W complete independently; the phase ends once both have fired.
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_done_q | aw_fire;
          w_done_d  = w_done_q | w_fire;
        end
      end

      WR_RESP: begin
        if (bvalid_i) begin
          if (bresp_i[1]) begin
            wr_err_d = sat_inc(wr_err_q);
            if (!err_valid_q) begin
              err_valid_d = 1'b1;
              first_err_d = cur_addr;
            end
          end
          idx_d  = idx_q + IDX_W'(1);
          lfsr_d = lfsr_next;
          if (stop_i) begin
            state_d = DONE;
          end else if (last_word) begin
            idx_d   = '0;
            lfsr_d  = seed_q;
            state_d = RD_REQ;
          end else begin
            state_d = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        if (arready_i) begin
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        if (rvalid_i) begin
          if (rd_bad) begin
            rd_err_d = sat_inc(rd_err_q);
            if (!err_valid_q) begin
              err_valid_d = 1'b1;
              first_err_d = cur_addr;
            end
          end
          idx_d  = idx_q + IDX_W'(1);
          lfsr_d = lfsr_next;
          if (last_word) begin
            pass_cnt_d = sat_inc(pass_cnt_q);
            if (stop_i || ((passes_q != '0) && ((pass_cnt_q + CNT_WIDTH'(1)) == passes_q))) begin
              state_d = DONE;
            end else begin
              idx_d   = '0;
              lfsr_d  = seed_q;
              state_d = WR_REQ;
            end
          end else if (stop_i) begin
            state_d = DONE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign awaddr_o         = cur_addr;
  assign araddr_o         = cur_addr;
  assign awprot_o         = 3'b001;
  assign arprot_o         = 3'b001;
  assign wdata_o          = pattern;
  assign wstrb_o          = '1;
  assign awvalid_o        = (state_q == WR_REQ) & ~aw_done_q;
  assign wvalid_o         = (state_q == WR_REQ) & ~w_done_q;
  assign bready_o         = (state_q == WR_RESP);
  assign arvalid_o        = (state_q == RD_REQ);
  assign rready_o         = (state_q == RD_DATA);
  assign busy_o           = (state_q != IDLE) && (state_q != DONE);
  assign done_o           = (state_q == DONE);
  assign pass_cnt_o       = pass_cnt_q;
  assign wr_err_cnt_o     = wr_err_q;
  assign rd_err_cnt_o     = rd_err_q;
  assign err_valid_o      = err_valid_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_axi4_lite_traffic_gen_multi.sv
// Directed bench for axi4_lite_traffic_gen_multi with a small AXI4-Lite memory slave.
module tb_axi4_lite_traffic_gen_multi;

  localparam int AW = 28;
  localparam int DW = 64;
  localparam int NW = 4;
  localparam int CW = 16;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic            start_i = 1'b0;
  logic            stop_i = 1'b0;
  logic [1:0]      mode_i = '0;
  logic [CW-1:0]   passes_i = '0;
  logic [31:0]     seed_i = '0;
  logic [AW-1:0]   awaddr_o, araddr_o, first_err_addr_o;
  logic [2:0]      awprot_o, arprot_o;
  logic            awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
  logic            awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0;
  logic            arready_i = 1'b0, rvalid_i = 1'b0;
  logic [DW-1:0]   wdata_o;
  logic [DW/8-1:0] wstrb_o;
  logic [1:0]      bresp_i = '0, rresp_i = '0;
  logic [DW-1:0]   rdata_i = '0;
  logic            busy_o, done_o, err_valid_o;
  logic [CW-1:0]   pass_cnt_o, wr_err_cnt_o, rd_err_cnt_o;

  int total = 0;
  int bad = 0;

  axi4_lite_traffic_gen_multi #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(64'h100), .NUM_WORDS(NW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .passes_i(passes_i), .seed_i(seed_i),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .busy_o(busy_o), .done_o(done_o), .pass_cnt_o(pass_cnt_o),
    .wr_err_cnt_o(wr_err_cnt_o), .rd_err_cnt_o(rd_err_cnt_o),
    .err_valid_o(err_valid_o), .first_err_addr_o(first_err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave knobs and bookkeeping.
  int aw_delay = 0, w_delay = 0, bad_b = -1, bad_r = -1;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  int aw_wait = 0, w_wait = 0, aw_len = 0, w_len = 0;
  logic [AW-1:0] aw_q[$];
  logic [DW-1:0] w_q[$];
  logic [AW-1:0] ar_q[$];
  logic [DW-1:0] mem [4];
  logic [AW-1:0] wr_addr_log [64];
  logic [DW-1:0] wr_data_log [64];
  logic [AW-1:0] sl_a;
  logic [DW-1:0] sl_d;

  // DUT outputs depend only on its registered state, so readies/valids chosen on the
  // falling edge decide exactly which handshakes happen at the next rising edge.
  always @(negedge clk_i) begin
    if (reset_i) begin
      awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
      bresp_i = 0; rresp_i = 0; aw_wait = 0; w_wait = 0;
      aw_q.delete(); w_q.delete(); ar_q.delete();
    end else begin
      if (awvalid_o) begin
        if (aw_wait >= aw_delay) begin
          awready_i = 1; aw_q.push_back(awaddr_o); aw_n++; aw_len = aw_wait + 1; aw_wait = 0;
        end else begin
          awready_i = 0; aw_wait++;
        end
      end else begin
        awready_i = 0; aw_wait = 0;
      end
      if (wvalid_o) begin
        if (w_wait >= w_delay) begin
          wready_i = 1; w_q.push_back(wdata_o); w_n++; w_len = w_wait + 1; w_wait = 0;
        end else begin
          wready_i = 0; w_wait++;
        end
      end else begin
        wready_i = 0; w_wait = 0;
      end
      bvalid_i = 0; bresp_i = 0;
      if (bready_o && aw_q.size() > 0 && w_q.size() > 0) begin
        sl_a = aw_q.pop_front(); sl_d = w_q.pop_front();
        mem[sl_a[4:3]] = sl_d;
        if (b_n < 64) begin wr_addr_log[b_n] = sl_a; wr_data_log[b_n] = sl_d; end
        bresp_i = (b_n == bad_b) ? 2'b10 : 2'b00;
        bvalid_i = 1;
        $display("B #%0d addr=%h data=%h resp=%0d", b_n, sl_a, sl_d, bresp_i);
        b_n++;
      end
      if (arvalid_o) begin
        arready_i = 1; ar_q.push_back(araddr_o); ar_n++;
      end else begin
        arready_i = 0;
      end
      rvalid_i = 0; rresp_i = 0;
      if (rready_o && ar_q.size() > 0) begin
        sl_a = ar_q.pop_front();
        rdata_i = mem[sl_a[4:3]] ^ ((r_n == bad_r) ? 64'h1 : 64'h0);
        rvalid_i = 1;
        $display("R #%0d addr=%h data=%h", r_n, sl_a, rdata_i);
        r_n++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i); #1;
  endtask

  task automatic clr();
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; aw_len = 0; w_len = 0;
  endtask

  task automatic run(input logic [1:0] m, input logic [CW-1:0] p, input logic [31:0] s);
    step();
    mode_i = m; passes_i = p; seed_i = s; start_i = 1;
    step();
    start_i = 0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done_o && n < budget) begin step(); n++; end
    check(tag, done_o, 1'b1);
  endtask

  function automatic bit cond(input int sel);
    if (sel == 0) return (b_n >= 1) && awvalid_o;
    return (pass_cnt_o == 1) && rready_o;
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag);
    int n = 0;
    while (!cond(sel) && n < budget) begin step(); n++; end
    check(tag, cond(sel), 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}, 0);
    check("rst_pass", pass_cnt_o, 0);
    check("rst_errv", err_valid_o, 0);
    check("rst_ferr", first_err_addr_o, 0);
    reset_i = 0;
    step();

    // Ideal slave, address pattern, one pass
    clr();
    run(2'd0, 16'd1, 32'd0);
    check("t1_awvalid", awvalid_o, 1);
    check("t1_awaddr", awaddr_o, 28'h100);
    check("t1_wdata", wdata_o, 64'h100);
    check("t1_wstrb", wstrb_o, 8'hFF);
    check("t1_awprot", awprot_o, 3'b001);
    wait_done(200, "t1_done");
    check("t1_bn", b_n, 4);
    check("t1_rn", r_n, 4);
    for (int k = 0; k < 4; k++) begin
      check("t1_addr", wr_addr_log[k], 28'h100 + 28'(k * 8));
      check("t1_data", wr_data_log[k], 64'h100 + 64'(k * 8));
    end
    check("t1_wrerr", wr_err_cnt_o, 0);
    check("t1_rderr", rd_err_cnt_o, 0);
    check("t1_pass", pass_cnt_o, 1);
    check("t1_busy", busy_o, 0);

    // AW delayed by 3, W immediate
    clr(); aw_delay = 3; w_delay = 0;
    run(2'd0, 16'd1, 32'd0);
    step();
    check("t2_wdrop", wvalid_o, 0);
    check("t2_awhold", awvalid_o, 1);
    wait_done(300, "t2_done");
    check("t2_awlen", aw_len, 4);
    check("t2_wlen", w_len, 1);
    check("t2_counts", {8'(aw_n), 8'(w_n), 8'(b_n), 8'(r_n)}, {8'd4, 8'd4, 8'd4, 8'd4});
    check("t2_rderr", rd_err_cnt_o, 0);

    // Reverse ordering: W delayed by 3
    clr(); aw_delay = 0; w_delay = 3;
    run(2'd0, 16'd1, 32'd0);
    wait_done(300, "t2r_done");
    check("t2r_wlen", w_len, 4);
    check("t2r_awlen", aw_len, 1);
    check("t2r_counts", {8'(aw_n), 8'(w_n), 8'(b_n), 8'(r_n)}, {8'd4, 8'd4, 8'd4, 8'd4});
    check("t2r_errs", {wr_err_cnt_o, rd_err_cnt_o}, 0);
    check("t2r_pass", pass_cnt_o, 1);

    // SLVERR on 2nd write, corrupted read of word 2
    clr(); w_delay = 0; bad_b = 1; bad_r = 2;
    run(2'd0, 16'd1, 32'd0);
    wait_done(200, "t3_done");
    check("t3_wrerr", wr_err_cnt_o, 1);
    check("t3_rderr", rd_err_cnt_o, 1);
    check("t3_ferr", first_err_addr_o, 28'h108);
    check("t3_errv", err_valid_o, 1);
    check("t3_pass", pass_cnt_o, 1);
    bad_b = -1; bad_r = -1;

    // LFSR pattern, seed 0, three passes
    clr();
    run(2'd2, 16'd3, 32'd0);
    wait_done(600, "t4_done");
    check("t4_bn", b_n, 12);
    check("t4_rn", r_n, 12);
    check("t4_errs", {wr_err_cnt_o, rd_err_cnt_o}, 0);
    check("t4_pass", pass_cnt_o, 3);
    check("t4_d0", wr_data_log[0], 64'h00000001_00000001);
    check("t4_d1", wr_data_log[1], 64'h80200003_80200003);
    check("t4_d2", wr_data_log[2], 64'hC0300002_C0300002);
    check("t4_d8", wr_data_log[8], 64'h00000001_00000001);
    check("t4_a11", wr_addr_log[11], 28'h118);

    // Inverted address and walking-one patterns
    clr();
    run(2'd1, 16'd1, 32'd0);
    wait_done(200, "t4m1_done");
    check("t4m1_d0", wr_data_log[0], 64'hFFFF_FFFF_FFFF_FEFF);
    check("t4m1_rderr", rd_err_cnt_o, 0);
    clr();
    run(2'd3, 16'd1, 32'd0);
    wait_done(200, "t4m3_done");
    check("t4m3_d3", wr_data_log[3], 64'h8);
    check("t4m3_rderr", rd_err_cnt_o, 0);

    // Endless run stopped during the write of word 1
    clr(); aw_delay = 3;
    run(2'd0, 16'd0, 32'd0);
    wait_for(0, 100, "t5_word1");
    stop_i = 1;
    wait_done(100, "t5_done");
    stop_i = 0;
    check("t5_bn", b_n, 2);
    check("t5_pass", pass_cnt_o, 0);
    repeat (10) step();
    check("t5_awn", aw_n, 2);
    check("t5_rn", r_n, 0);
    check("t5_hold", done_o, 1);

    // Reset in RD_DATA of the second pass
    clr(); aw_delay = 0; bad_r = 0;
    run(2'd0, 16'd2, 32'd0);
    wait_for(1, 200, "t6_rddata");
    check("t6_pre_rderr", rd_err_cnt_o, 1);
    check("t6_pre_errv", err_valid_o, 1);
    reset_i = 1;
    #1;
    check("t6_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}, 0);
    check("t6_busy", busy_o, 0);
    check("t6_cnts", {pass_cnt_o, wr_err_cnt_o, rd_err_cnt_o}, 0);
    check("t6_errv", err_valid_o, 0);
    step();
    reset_i = 0;
    bad_r = -1;
    step();
    clr();
    run(2'd0, 16'd1, 32'd0);
    wait_done(200, "t6_rerun");
    check("t6_rr_pass", pass_cnt_o, 1);
    check("t6_rr_errs", {wr_err_cnt_o, rd_err_cnt_o}, 0);
    check("t6_rr_bn", b_n, 4);
    check("t6_rr_rn", r_n, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
